// File: rtl/r32m_pkg.sv
// r32m_pkg: shared RV32M divider opcodes, FSM state type and iteration count.
package r32m_pkg;
    localparam logic [1:0] DIVC  = 2'd0;
    localparam logic [1:0] DIVUC = 2'd1;
    localparam logic [1:0] REMC  = 2'd2;
    localparam logic [1:0] REMUC = 2'd3;
    localparam int DIV_ITERS = 32;
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step_r32m.sv
// div_step_r32m: one combinational restoring-division step.
module div_step_r32m (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);
    logic [32:0] w_shift;
    logic        w_ge;
    always_comb begin
        w_shift = {i_rem, i_quo[31]};
        w_ge    = w_shift >= {1'b0, i_divisor};
        o_rem   = w_ge ? 32'(w_shift - {1'b0, i_divisor}) : w_shift[31:0];
        o_quo   = {i_quo[30:0], w_ge};
    end
endmodule

// File: rtl/div_sequencer_r32m.sv
// div_sequencer_r32m: multi-cycle DIV/DIVU/REM/REMU controller with
// divide-by-zero and signed-overflow fast paths.
module div_sequencer_r32m
    import r32m_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       divCode,
    input  logic [dataW-1:0] DivD,
    input  logic [dataW-1:0] DivI,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [dataW-1:0] result
);
    div_state_t  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem, r_quo, r_dvs;
    logic        r_is_rem, r_neg_q, r_neg_r;
    logic [31:0] w_rem, w_quo, w_mag_d, w_mag_i, w_fast;
    logic        w_acc, w_sgn, w_rem_op, w_dz, w_ovf;

    assign ready    = r_state == IDLE || r_state == DONE;
    assign busy     = r_state == ITER || r_state == FIX;
    assign done     = r_state == DONE;
    assign w_acc    = start && ready && !flush;
    assign w_sgn    = divCode == DIVC || divCode == REMC;
    assign w_rem_op = divCode == REMC || divCode == REMUC;
    // -0x8000_0000 wraps to itself, which is the correct unsigned magnitude
    assign w_mag_d  = (w_sgn && DivD[31]) ? -DivD : DivD;
    assign w_mag_i  = (w_sgn && DivI[31]) ? -DivI : DivI;
    assign w_dz     = DivI == '0;
    assign w_ovf    = w_sgn && DivD == 32'h8000_0000 && DivI == 32'hFFFF_FFFF;
    assign w_fast   = w_dz ? (w_rem_op ? DivD : 32'hFFFF_FFFF)
                           : (w_rem_op ? 32'h0 : 32'h8000_0000);

    div_step_r32m u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else if (w_acc) begin
            r_is_rem <= w_rem_op;
            r_neg_q  <= w_sgn && (DivD[31] ^ DivI[31]);
            r_neg_r  <= w_sgn && DivD[31];
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_mag_d;
            r_dvs    <= w_mag_i;
            r_state  <= (w_dz || w_ovf) ? DONE : ITER;
            if (w_dz || w_ovf)
                result <= w_fast;
        end else if (r_state == ITER) begin
            r_rem   <= w_rem;
            r_quo   <= w_quo;
            r_cnt   <= r_cnt + 5'd1;
            r_state <= (r_cnt == 5'(DIV_ITERS - 1)) ? FIX : ITER;
        end else if (r_state == FIX) begin
            result  <= r_is_rem ? (r_neg_r ? -r_rem : r_rem) : (r_neg_q ? -r_quo : r_quo);
            r_state <= DONE;
        end else begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_div_sequencer_r32m.sv
// tb_div_sequencer_r32m: scoreboard bench with an arithmetic reference model
// for the RV32M divide sequencer.
module tb_div_sequencer_r32m;
    import r32m_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    logic        clk = 1'b0, nRst = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]  divCode = 2'd0;
    logic [31:0] DivD = '0, DivI = '0;
    logic        ready, busy, done;
    logic [31:0] result;
    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0, n_vec = 0, n_err = 0;

    div_sequencer_r32m #(.dataW(32)) dut (
        .clk     (clk),
        .nRst    (nRst),
        .start   (start),
        .flush   (flush),
        .divCode (divCode),
        .DivD    (DivD),
        .DivI    (DivI),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        bit sg = (c == DIVC || c == REMC);
        bit rm = (c == REMC || c == REMUC);
        if (b == 0) return rm ? a : 32'hFFFF_FFFF;
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
        if (sg) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rm ? a % b : a / b;
    endfunction

    function automatic int model_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        bit sg = (c == DIVC || c == REMC);
        return (b == 0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 0 : 33;
    endfunction

    always @(negedge clk) begin
        if (nRst && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected done: result %h with no request pending", result);
            end else begin
                e = sb.pop_front();
                chk({e.name, " result"}, result, e.res);
                chk({e.name, " latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input string nm, output int acc);
        int w = 0;
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        acc = -1;
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: ready never rose (ready=%b)", nm, ready);
            return;
        end
        divCode = c;
        DivD    = a;
        DivI    = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) sb.push_back('{model(c, a, b), cyc, model_lat(c, a, b), nm});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc, acc2, dcyc, w;
        bit all_busy;
        logic [31:0] prev, a, b;
        logic [1:0] c;
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        issue(DIVC, 32'd100, -32'sd7, 1'b1, "DIVC 100/-7", acc);
        all_busy = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (!busy) all_busy = 1'b0;
            @(negedge clk);
        end
        chk("busy during DIVC", 32'(all_busy), 32'd1);
        drain();

        issue(REMC, -32'sd100, 32'd7, 1'b1, "REMC -100/7", acc);
        issue(REMUC, 32'hFFFF_FFFF, 32'd16, 1'b1, "REMUC ffffffff/16", acc);
        drain();

        issue(DIVUC, 32'd1234, 32'd0, 1'b1, "DIVUC 1234/0", acc);
        chk("busy DIVUC by zero", 32'(busy), 32'd0);
        issue(REMC, -32'sd5, 32'd0, 1'b1, "REMC -5/0", acc);
        chk("busy REMC by zero", 32'(busy), 32'd0);
        issue(DIVC, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "DIVC overflow", acc);
        chk("busy DIVC overflow", 32'(busy), 32'd0);
        issue(REMC, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "REMC overflow", acc);
        chk("busy REMC overflow", 32'(busy), 32'd0);
        drain();

        prev = result;
        issue(DIVUC, 32'd1000, 32'd3, 1'b0, "DIVUC flushed", acc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("ready after flush", 32'(ready), 32'd1);
        chk("busy after flush", 32'(busy), 32'd0);
        chk("result after flush", result, prev);
        repeat (40) @(negedge clk);
        issue(DIVUC, 32'd1000, 32'd3, 1'b1, "DIVUC 1000/3", acc);
        drain();

        issue(DIVC, 32'd12345, 32'd17, 1'b0, "DIVC reset", acc);
        repeat (5) @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        chk("async reset ready", 32'(ready), 32'd1);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset result", result, 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        repeat (40) @(negedge clk);

        issue(DIVUC, 32'd5000, 32'd7, 1'b1, "DIVUC 5000/7 with busy start", acc);
        repeat (3) @(negedge clk);
        divCode = REMUC;
        DivD    = 32'd1;
        DivI    = 32'd1;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        issue(DIVC, -32'sd999, 32'd10, 1'b1, "DIVC -999/10", acc);
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        dcyc = cyc;
        issue(REMC, -32'sd999, 32'd10, 1'b1, "REMC -999/10", acc2);
        chk("back-to-back accept cycle", 32'(acc2), 32'(dcyc + 1));
        drain();

        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            issue(c, a, b, 1'b1, $sformatf("rand%0d op%0d %h/%h", i, c, a, b), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_sequencer_r32m.md
# div_sequencer_r32m

Multi-cycle controller for RV32M divide/remainder. It accepts one DIV/DIVU/REM/REMU request at a time from the execute stage. It runs a 32-iteration restoring division on a shared remainder/quotient register pair, applies RISC-V special-case and sign rules, and returns a 32-bit result with a one-cycle done pulse. The ALU routes divider opcodes here, and the pipeline stalls on `busy`.

## Interface
- `dataW`, 32: operand/result width; only 32 is supported.
- `clk`  in  1: clock; all state updates on the rising edge.
- `nRst`  in  1: asynchronous reset, active-low.
- `start`  in  1: request strobe; accepted only when `ready`=1.
- `flush`  in  1: synchronous abort of any in-flight operation.
- `divCode`  in  2: DIVC, DIVUC, REMC, REMUC (shared codes).
- `DivD`  in  32: dividend (rs1).
- `DivI`  in  32: divisor (rs2).
- `ready`  out  1: high in IDLE or DONE.
- `busy`  out  1: high in ITER or FIX; this is the pipeline stall request.
- `done`  out  1: single-cycle pulse, high only in DONE.
- `result`  out  32: quotient or remainder; held until the next accept.

## Operation
- States: IDLE, ITER, FIX, DONE.
- Reset: state=IDLE, `result`=0, `done`=0, `busy`=0, `ready`=1, counter=0.
- Accept condition: `start`=1, `ready`=1 and `flush`=0. On accept, latch `divCode`, the operand signs, and the special-case flags.
- Signed codes (DIVC, REMC): operate on magnitudes |DivD| and |DivI|. |−2^31| is taken as the unsigned value 0x8000_0000.
- Unsigned codes: operands are used as-is.
- Divide-by-zero (`DivI`=0) is a fast path that goes straight to DONE:
  - quotient = 0xFFFF_FFFF for both DIV and DIVU;
  - remainder = `DivD` unmodified.
- Signed overflow (DIVC/REMC, `DivD`=0x8000_0000, `DivI`=0xFFFF_FFFF) is a fast path that goes straight to DONE:
  - quotient = 0x8000_0000;
  - remainder = 0.
- Otherwise go to ITER with rem=0, quo=|dividend| (33-bit rem), counter=0.
- ITER performs one restoring step per cycle:
  - trial = {rem[31:0], quo[31]} − {1'b0, divisor};
  - if trial ≥ 0: rem=trial, quo={quo[30:0],1}; else rem={rem[31:0],quo[31]}, quo={quo[30:0],0}.
  - Increment the counter each step. After the step with counter=31, go to FIX.
- FIX:
  - quotient is negated when signed and sign(DivD)≠sign(DivI);
  - remainder is negated when signed and DivD<0;
  - write the selected value to `result`, then go to DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless a new request is accepted in DONE, in which case it goes directly to ITER or back to DONE.
- `flush`=1 in any state: next state IDLE, no `done` pulse, `result` unchanged. Flush has priority over a simultaneous `start`.
- `start` while `busy` is ignored; there is no queueing.
- Reset mid-operation: immediate return to the reset values, and no `done`.

## Timing
- Normal path, request accepted at edge k:
  - ITER steps occur on edges k+1..k+32;
  - FIX writes `result` on edge k+33;
  - `done` is high from edge k+33 to edge k+34.
  - Latency is 33 cycles; `busy` is high from edge k to edge k+33.
- Fast path (divide-by-zero or overflow), accepted at edge k: `result` is written and `done` is high from edge k to k+1. `busy` never rises.
- Back-to-back: a new `start` accepted during DONE gives zero idle cycles between operations.
- `result` is registered. Outputs have no combinational path from the inputs except `ready`, which decodes state only.

## Structure
- Shared package `r32m_pkg`:
  - DIVC/DIVUC/REMC/REMUC codes (replacing the current include file);
  - enum `div_state_t`;
  - constant `DIV_ITERS`=32.
- Sub-module `div_step_r32m` is purely combinational and implements one restoring step: inputs rem, quo, divisor; outputs next rem and next quo.
- The controller FSM, counter, sign/special-case handling and result register live in `div_sequencer_r32m`.

## Test plan
- DIVC with 100 / −7 → `result`=0xFFFF_FFF2 (−14); `done` pulse exactly 33 cycles after accept; `busy` high throughout.
- REMC with −100 / 7 → `result`=0xFFFF_FFFE (−2); REMUC with 0xFFFF_FFFF / 16 → 0x0000_000F.
- Divide-by-zero: DIVUC 1234/0 → 0xFFFF_FFFF; REMC −5/0 → 0xFFFF_FFFB. Both give `done` one cycle after accept, and `busy` never rises.
- Overflow: DIVC 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REMC with the same operands → 0. Both complete in one cycle.
- Flush at iteration 10 of DIVUC 1000/3: no `done`, `result` keeps its previous value, and `ready` rises next cycle. A following DIVUC 1000/3 → 333.
- `nRst` asserted mid-ITER → all outputs return to reset values asynchronously. A `start` during `busy` is ignored, and a `start` during DONE yields back-to-back results with no gap.
